// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
//
// One operation is in flight at a time. Arithmetic, logic and zero-amount
// shifts finish one cycle after acceptance. Shifts with a non-zero amount
// move one bit per cycle, unless the build defines SEQ_ALU_BARREL_EN, which
// swaps in a combinational barrel shifter so every shift also finishes in
// one cycle. Results and flags are the same in both builds.
//
// SC is a persistent carry flag. It feeds ADDC/SUBB and keeps its value
// across operations that do not define a new carry.

module seq_alu #(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [W-1:0]  InputA,
    input  logic [W-1:0]  InputB,
    input  logic [3:0]    OP,
    input  logic          InValid,
    output logic          InReady,
    output logic [W-1:0]  Out,
    output logic          OutValid,
    input  logic          OutReady,
    output logic          SC,
    output logic          Zero,
    output logic          Err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBB = 4'd3;
    localparam logic [3:0] OP_LSH  = 4'd4;
    localparam logic [3:0] OP_RSH  = 4'd5;
    localparam logic [3:0] OP_ASR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_CLR  = 4'd10;
    localparam logic [3:0] OP_XORA = 4'd11;

    localparam logic [SW-1:0] AMT_ZERO = '0;
    localparam logic [SW-1:0] AMT_ONE  = SW'(1);

`ifdef SEQ_ALU_BARREL_EN
    localparam bit BARREL_EN = 1'b1;
`else
    localparam bit BARREL_EN = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    work_q,  work_d;
    logic [SW-1:0]   cnt_q,   cnt_d;
    logic [3:0]      op_q,    op_d;
    logic [W-1:0]    out_q,   out_d;
    logic            sc_q,    sc_d;
    logic            err_q,   err_d;

    // Shift a by amt for LSH/RSH/ASR; returns {carry, result}. The carry is
    // the last bit shifted out, or the incoming carry when amt is zero. The
    // iterative path calls this with amt = 1 every cycle, so both builds
    // share exactly one definition of shift behaviour.
    function automatic logic [W:0] shift_calc(
        input logic [3:0]    op,
        input logic [W-1:0]  a,
        input logic [SW-1:0] amt,
        input logic          sc_in
    );
        logic [W:0]        ext;
        logic signed [W:0] sext;
        logic [W:0]        res;
        ext  = '0;
        sext = '0;
        res  = {sc_in, a};
        case (op)
            OP_LSH: begin
                ext = {1'b0, a} << amt;
                res = ext;
            end
            OP_RSH: begin
                ext = {a, 1'b0} >> amt;
                res = {ext[0], ext[W:1]};
            end
            OP_ASR: begin
                sext = $signed({a, 1'b0}) >>> amt;
                ext  = sext;
                res  = {ext[0], ext[W:1]};
            end
            default: res = {sc_in, a};
        endcase
        if (amt == AMT_ZERO) begin
            res[W] = sc_in;
        end
        return res;
    endfunction

    // Single-cycle result for every opcode; returns {err, carry, result}.
    function automatic logic [W+1:0] alu_calc(
        input logic [3:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         sc_in
    );
        logic [W:0]   sum;
        logic [W:0]   cin;
        logic [W:0]   sh;
        logic [W+1:0] res;
        sum = '0;
        sh  = '0;
        cin = {{W{1'b0}}, sc_in};
        res = {1'b0, sc_in, {W{1'b0}}};
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = {1'b0, sum};
            end
            OP_ADDC: begin
                sum = {1'b0, a} + {1'b0, b} + cin;
                res = {1'b0, sum};
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                res = {1'b0, sum};
            end
            OP_SUBB: begin
                sum = {1'b0, a} + {1'b0, ~b} + cin;
                res = {1'b0, sum};
            end
            OP_LSH, OP_RSH, OP_ASR: begin
                sh  = shift_calc(op, a, b[SW-1:0], sc_in);
                res = {1'b0, sh};
            end
            OP_XOR:  res = {1'b0, sc_in, a ^ b};
            OP_OR:   res = {1'b0, sc_in, a | b};
            OP_AND:  res = {1'b0, sc_in, a & b};
            OP_CLR:  res = {1'b0, 1'b0, {W{1'b0}}};
            OP_XORA: res = {1'b0, sc_in, ^a[W-2:0], {(W-1){1'b0}}};
            default: res = {1'b1, sc_in, {W{1'b0}}};
        endcase
        return res;
    endfunction

    // Next-state and datapath: accept in IDLE, step the shifter in SHIFT,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        logic        is_shift;
        logic [W:0]  step;
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        out_d    = out_q;
        sc_d     = sc_q;
        err_d    = err_q;
        is_shift = 1'b0;
        step     = '0;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    is_shift = (OP == OP_LSH) || (OP == OP_RSH) || (OP == OP_ASR);
                    if (!BARREL_EN && is_shift && (InputB[SW-1:0] != AMT_ZERO)) begin
                        work_d  = InputA;
                        cnt_d   = InputB[SW-1:0];
                        op_d    = OP;
                        state_d = SHIFT;
                    end else begin
                        {err_d, sc_d, out_d} = alu_calc(OP, InputA, InputB, sc_q);
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                step = shift_calc(op_q, work_q, AMT_ONE, sc_q);
                if (cnt_q == AMT_ONE) begin
                    out_d   = step[W-1:0];
                    sc_d    = step[W];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    work_d = step[W-1:0];
                    cnt_d  = cnt_q - AMT_ONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
            sc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
            sc_q    <= sc_d;
            err_q   <= err_d;
        end
    end

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Out      = out_q;
    assign SC       = sc_q;
    assign Err      = err_q;
    assign Zero     = (out_q == '0);

endmodule
